// File: rtl/ref_win_pkg.sv
// Shared types and sizing helpers for the reference search-window buffer.
// The FSM encoding and the counter-width helper live here so the bank RAM and top agree.
package ref_win_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int DEF_PIX_W           = 8;
    localparam int DEF_PIX_PER_WORD    = 8;
    localparam int DEF_NUM_BANKS       = 4;
    localparam int DEF_DEPTH           = 23;
    localparam int DEF_OUT_PIX         = 23;
    localparam int DEF_BLOCKS_PER_LINE = 482;
    localparam int DEF_NB_ADDR         = 8;
    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_ADDR_STEP       = 8;

    // Bits needed to index n distinct values (at least one bit).
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ref_bank_ram.sv
// Single-port bank: synchronous write, registered read with read enable.
// Kept behavioural and reset-free so a foundry macro can replace it one-for-one.
module ref_bank_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 23,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Read-first port: a read in a write cycle returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/ref_window_buffer.sv
// Ring of single-port reference banks: one bank is written per pass while the
// others are read row-by-row to build the search-window row for the SAD array.
module ref_window_buffer
    import ref_win_pkg::*;
#(
    parameter int PIX_W           = DEF_PIX_W,
    parameter int PIX_PER_WORD    = DEF_PIX_PER_WORD,
    parameter int NUM_BANKS       = DEF_NUM_BANKS,
    parameter int DEPTH           = DEF_DEPTH,
    parameter int OUT_PIX         = DEF_OUT_PIX,
    parameter int BLOCKS_PER_LINE = DEF_BLOCKS_PER_LINE,
    parameter int NB_ADDR         = DEF_NB_ADDR,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int ADDR_STEP       = DEF_ADDR_STEP
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      line_start,
    input  logic [ADDR_W-1:0]         line_base,
    input  logic [PIX_W*PIX_PER_WORD-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [PIX_W*OUT_PIX-1:0]  win_data,
    output logic                      win_valid,
    output logic                      next_block,
    output logic                      line_done
);

    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int WIN_W  = PIX_W * OUT_PIX;
    localparam int CAT_W  = (NUM_BANKS - 1) * WORD_W;
    localparam int ROW_W  = width_of(DEPTH);
    localparam int BANK_W = width_of(NUM_BANKS);
    localparam int PASS_W = width_of(BLOCKS_PER_LINE + 1);

    state_t              state_r;
    state_t              state_s;
    logic [ROW_W-1:0]    row_r;
    logic [BANK_W-1:0]   wbank_r;
    logic [BANK_W-1:0]   wbank_nxt_s;
    logic [BANK_W-1:0]   sel_bank_r;
    logic [PASS_W-1:0]   pass_cnt_r;
    logic [PASS_W-1:0]   pass_nxt_s;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                win_valid_r;
    logic                next_block_r;
    logic                line_done_r;
    logic [WIN_W-1:0]    hold_r;
    logic [WIN_W-1:0]    win_s;
    logic [CAT_W-1:0]    cat_s;
    logic [WORD_W-1:0]   q_s [NUM_BANKS];
    logic                restart_s;
    logic                writing_s;
    logic                accept_s;
    logic                step_s;
    logic                read_s;
    logic                last_row_s;

    assign restart_s  = en && line_start;
    assign writing_s  = (state_r == ST_FILL) || (state_r == ST_RUN);
    assign accept_s   = !restart_s && en && in_valid && writing_s;
    assign step_s     = accept_s || (!restart_s && en && (state_r == ST_DRAIN));
    assign read_s     = step_s && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    assign last_row_s = (row_r == ROW_W'(DEPTH - 1));
    assign pass_nxt_s = pass_cnt_r + PASS_W'(1);
    assign wbank_nxt_s = (wbank_r == BANK_W'(NUM_BANKS - 1)) ? '0 : wbank_r + BANK_W'(1);

    assign in_ready   = en && writing_s;
    assign mem_addr   = mem_addr_r;
    assign win_valid  = win_valid_r && en;
    assign next_block = next_block_r && en;
    assign line_done  = line_done_r && en;

    genvar g;
    generate
        for (g = 0; g < NUM_BANKS; g++) begin : g_bank
            ref_bank_ram #(
                .DATA_W (WORD_W),
                .DEPTH  (DEPTH),
                .ADDR_W (ROW_W)
            ) u_bank (
                .clk   (clk),
                .we    (accept_s && (wbank_r == BANK_W'(g))),
                .re    (read_s),
                .addr  (row_r),
                .wdata (in_data),
                .rdata (q_s[g])
            );
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: pass boundaries move FILL->RUN->DRAIN->IDLE; line_start always restarts.
    always_comb begin
        state_s = state_r;
        if (restart_s) begin
            state_s = ST_FILL;
        end else if (step_s && last_row_s) begin
            case (state_r)
                ST_FILL: begin
                    if (pass_nxt_s == PASS_W'(NUM_BANKS - 1)) state_s = ST_RUN;
                    else state_s = ST_FILL;
                end
                ST_RUN: begin
                    if (pass_nxt_s == PASS_W'(BLOCKS_PER_LINE)) state_s = ST_DRAIN;
                    else state_s = ST_RUN;
                end
                ST_DRAIN: state_s = ST_DRAIN == ST_DRAIN ? ST_IDLE : ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Row/bank/pass counters, fetch address and the one-cycle output flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_r        <= '0;
            wbank_r      <= '0;
            pass_cnt_r   <= '0;
            mem_addr_r   <= '0;
            sel_bank_r   <= '0;
            win_valid_r  <= 1'b0;
            next_block_r <= 1'b0;
            line_done_r  <= 1'b0;
        end else if (restart_s) begin
            row_r        <= '0;
            wbank_r      <= '0;
            pass_cnt_r   <= '0;
            mem_addr_r   <= line_base;
            win_valid_r  <= 1'b0;
            next_block_r <= 1'b0;
            line_done_r  <= 1'b0;
        end else begin
            win_valid_r  <= read_s;
            next_block_r <= read_s && (row_r == ROW_W'(NB_ADDR));
            line_done_r  <= step_s && (state_r == ST_DRAIN) && last_row_s;
            // The bank select is captured with the read so later writes cannot disturb it.
            if (read_s) begin
                sel_bank_r <= wbank_r;
            end
            if (accept_s) begin
                mem_addr_r <= mem_addr_r + ADDR_W'(ADDR_STEP);
            end
            if (step_s) begin
                if (last_row_s) begin
                    row_r      <= '0;
                    wbank_r    <= wbank_nxt_s;
                    pass_cnt_r <= pass_nxt_s;
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end
        end
    end

    // Concatenate the read banks oldest-first (the bank after the write bank is oldest).
    always_comb begin
        logic [BANK_W:0] bsum;
        cat_s = '0;
        bsum  = '0;
        for (int k = 1; k < NUM_BANKS; k++) begin
            bsum = {1'b0, sel_bank_r} + (BANK_W + 1)'(k);
            if (bsum >= (BANK_W + 1)'(NUM_BANKS)) begin
                bsum = bsum - (BANK_W + 1)'(NUM_BANKS);
            end else begin
                bsum = bsum;
            end
            cat_s[CAT_W - k * WORD_W +: WORD_W] = q_s[bsum[BANK_W-1:0]];
        end
    end

    assign win_s    = WIN_W'(cat_s >> (CAT_W - WIN_W));
    assign win_data = win_valid_r ? win_s : hold_r;

    // Holds the last presented window so win_data is stable between valid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= '0;
        end else begin
            hold_r <= win_data;
        end
    end

endmodule

// File: tb/tb_ref_window_buffer.sv
// Directed bench: default-parameter buffer plus a 3-bank/16-deep/12-pixel variant,
// both checked every cycle against a closed-form beat-index model.
module tb_ref_window_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         en;
    logic         line_start;
    logic [31:0]  line_base;
    logic [63:0]  in_data;
    logic         in_valid;

    logic         a_rdy, a_wv, a_nb, a_ld;
    logic [31:0]  a_addr;
    logic [183:0] a_wd;
    logic         b_rdy, b_wv, b_nb, b_ld;
    logic [31:0]  b_addr;
    logic [95:0]  b_wd;

    ref_window_buffer u_dut_a (
        .clk(clk), .rst(rst), .en(en), .line_start(line_start), .line_base(line_base),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_rdy), .mem_addr(a_addr),
        .win_data(a_wd), .win_valid(a_wv), .next_block(a_nb), .line_done(a_ld)
    );

    ref_window_buffer #(
        .PIX_W(8), .PIX_PER_WORD(8), .NUM_BANKS(3), .DEPTH(16), .OUT_PIX(12),
        .BLOCKS_PER_LINE(6), .NB_ADDR(5), .ADDR_W(32), .ADDR_STEP(8)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .line_start(line_start), .line_base(line_base),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_rdy), .mem_addr(b_addr),
        .win_data(b_wd), .win_valid(b_wv), .next_block(b_nb), .line_done(b_ld)
    );

    int checks = 0;
    int failures = 0;

    bit cur;
    int nb, dp, op, bpl, nba;

    bit           m_active;
    int           m_beats, m_drain;
    logic         exp_wv, exp_nb, exp_ld;
    logic [191:0] exp_wd;
    logic [31:0]  exp_addr;
    int           n_wv, n_nb, n_ld, n_acc;

    task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word(input int b);
        logic [15:0] x;
        x = b[15:0];
        return {x ^ 16'hA5C3, x, ~x, x + 16'h1234};
    endfunction

    // Window for a step at pass p, row r: bank (w+k) last held pass p-nb+k.
    function automatic logic [191:0] win(input int p, input int r);
        logic [255:0] acc;
        logic [191:0] mask;
        acc = '0;
        for (int k = 1; k < nb; k++) begin
            acc = {acc[191:0], word((p - nb + k) * dp + r)};
        end
        acc  = acc >> ((nb - 1) * 64 - op * 8);
        mask = '1;
        mask = mask >> (192 - op * 8);
        return acc[191:0] & mask;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_beats = 0; m_drain = 0;
        exp_wv = 1'b0; exp_nb = 1'b0; exp_ld = 1'b0;
        exp_wd = '0; exp_addr = '0;
    endtask

    task automatic count_reset();
        n_wv = 0; n_nb = 0; n_ld = 0; n_acc = 0;
    endtask

    // One clock: drive, check current outputs, advance the model at the edge.
    task automatic cyc(input logic v, input logic e, input logic ls, input logic [31:0] base);
        logic         o_rdy, o_wv, o_nb, o_ld;
        logic [31:0]  o_addr;
        logic [191:0] o_wd;
        int           p, r;
        in_valid = v; en = e; line_start = ls; line_base = base; in_data = word(m_beats);
        #1;
        o_rdy  = cur ? b_rdy  : a_rdy;
        o_wv   = cur ? b_wv   : a_wv;
        o_nb   = cur ? b_nb   : a_nb;
        o_ld   = cur ? b_ld   : a_ld;
        o_addr = cur ? b_addr : a_addr;
        o_wd   = cur ? {96'd0, b_wd} : {8'd0, a_wd};
        check_eq("in_ready",   192'(o_rdy),  192'(e && m_active && (m_beats < bpl * dp)));
        check_eq("win_valid",  192'(o_wv),   192'(exp_wv && e));
        check_eq("next_block", 192'(o_nb),   192'(exp_nb && e));
        check_eq("line_done",  192'(o_ld),   192'(exp_ld && e));
        check_eq("mem_addr",   192'(o_addr), 192'(exp_addr));
        check_eq("win_data",   o_wd,         exp_wd);
        n_wv += int'(o_wv); n_nb += int'(o_nb); n_ld += int'(o_ld);
        if (o_rdy && v) n_acc++;
        @(posedge clk);
        exp_wv = 1'b0; exp_nb = 1'b0; exp_ld = 1'b0;
        if (e && ls) begin
            m_active = 1'b1; m_beats = 0; m_drain = 0; exp_addr = base;
        end else if (e && m_active) begin
            if (m_beats < bpl * dp) begin
                if (v) begin
                    p = m_beats / dp; r = m_beats % dp;
                    if (p >= nb - 1) begin
                        exp_wv = 1'b1; exp_nb = (r == nba); exp_wd = win(p, r);
                    end
                    m_beats++;
                    exp_addr = exp_addr + 32'd8;
                end
            end else begin
                exp_wv = 1'b1; exp_nb = (m_drain == nba); exp_wd = win(bpl, m_drain);
                m_drain++;
                if (m_drain == dp) begin
                    m_active = 1'b0; exp_ld = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run_line(input int max_cyc, input bit stall);
        int g = 0;
        while (m_active && g < max_cyc) begin
            if (stall) cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), 1'b0, 32'd0);
            else       cyc(1'b1, 1'b1, 1'b0, 32'd0);
            g++;
        end
        check_eq("line_bound", 192'(m_active), 192'(1'b0));
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        logic [63:0] w46;
        rst = 1'b1; en = 1'b0; line_start = 1'b0; line_base = '0; in_data = '0; in_valid = 1'b0;
        cur = 1'b0; nb = 4; dp = 23; op = 23; bpl = 482; nba = 8;
        model_reset(); count_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) cyc(1'b0, 1'b1, 1'b0, 32'd0);

        // First window and full line, no stalls.
        count_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_1000);
        while (m_beats < 70) cyc(1'b1, 1'b1, 1'b0, 32'd0);
        #1;
        w46 = word(46);
        check_eq("first_win",   {8'd0, a_wd}, {8'd0, word(0), word(23), w46[63:8]});
        check_eq("first_addr",  192'(a_addr), 192'(32'h0000_1230));
        check_eq("first_wv",    192'(a_wv),   192'(1'b1));
        check_eq("no_early_wv", 192'(n_wv),   192'(0));
        run_line(12000, 1'b0);
        check_eq("full_accepts", 192'(n_acc), 192'(11086));
        check_eq("full_wv",      192'(n_wv),  192'(11040));
        check_eq("full_nb",      192'(n_nb),  192'(480));
        check_eq("full_ld",      192'(n_ld),  192'(1));

        // Abort at pass 100 with a simultaneous beat, then a stalled line from the new base.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_2000);
        while (m_beats < 2300) cyc(1'b1, 1'b1, 1'b0, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_8000);
        #1;
        check_eq("restart_addr", 192'(a_addr), 192'(32'h0000_8000));
        check_eq("restart_wv",   192'(a_wv),   192'(1'b0));
        run_line(60000, 1'b1);
        check_eq("stall_addr", 192'(a_addr), 192'(32'h0001_DA70));

        // Asynchronous reset between edges mid-RUN.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_3000);
        repeat (97) cyc(1'b1, 1'b1, 1'b0, 32'd0);
        #2;
        check_eq("pre_rst_wv", 192'(a_wv), 192'(1'b1));
        rst = 1'b1;
        #1;
        check_eq("rst_wv",    192'(a_wv),   192'(1'b0));
        check_eq("rst_ready", 192'(a_rdy),  192'(1'b0));
        check_eq("rst_addr",  192'(a_addr), 192'(32'd0));
        check_eq("rst_wd",    {8'd0, a_wd}, 192'd0);
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Small variant: window ordering and truncation.
        cur = 1'b1; nb = 3; dp = 16; op = 12; bpl = 6; nba = 5;
        count_reset();
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0400);
        run_line(200, 1'b0);
        check_eq("b_accepts", 192'(n_acc),  192'(96));
        check_eq("b_wv",      192'(n_wv),   192'(80));
        check_eq("b_nb",      192'(n_nb),   192'(5));
        check_eq("b_ld",      192'(n_ld),   192'(1));
        check_eq("b_addr",    192'(b_addr), 192'(32'h0000_0700));
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0000);
        run_line(2000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ref_window_buffer.md
Name: ref_window_buffer

Overview:
- Parametrised successor of the motion-estimation reference SRAM stage: a ring of NUM_BANKS single-port banks, each DEPTH words deep.
- Each pass writes one bank from the fetch stream while the other NUM_BANKS-1 banks are read to form an OUT_PIX-pixel search-window row.
- Adds over the previous generation: valid/ready input handshake with stall, per-line base address and restart, a clean drain pass, a line_done pulse, and generic width/depth/bank count.
- Sits between the reference-memory fetch path and the SAD array; next_block paces the current-block buffer.

Parameters:
PIX_W, 8, bits per pixel
PIX_PER_WORD, 8, pixels per bank word / input beat
NUM_BANKS, 4, banks in the ring (>=3)
DEPTH, 23, words per bank = rows per pass
OUT_PIX, 23, window pixels output; must be <= (NUM_BANKS-1)*PIX_PER_WORD
BLOCKS_PER_LINE, 482, write passes per line
NB_ADDR, 8, row address at which next_block fires
ADDR_W, 32, memory address width
ADDR_STEP, 8, address increment per accepted beat

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
en  in  1  global advance enable; low freezes all state
line_start  in  1  pulse: begin a new line at line_base
line_base  in  ADDR_W  start address, sampled on line_start
in_data  in  PIX_W*PIX_PER_WORD  fetched reference word
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
mem_addr  out  ADDR_W  address of the next word to fetch
win_data  out  PIX_W*OUT_PIX  window row, oldest bank in MSBs
win_valid  out  1  win_data valid this cycle
next_block  out  1  one-cycle pulse to advance the current-block buffer
line_done  out  1  one-cycle pulse: line drained, block idle

Behaviour:
- Reset (async): state IDLE; row=0; wbank=0; pass_cnt=0; mem_addr=0; all outputs 0.
- States:
  - IDLE: in_ready=0. line_start -> FILL; load mem_addr=line_base, row=0, wbank=0, pass_cnt=0.
  - FILL: first NUM_BANKS-1 passes; writes only, no window output.
  - RUN: remaining write passes up to BLOCKS_PER_LINE total; writes and reads.
  - DRAIN: one read-only pass, in_ready=0.
- in_ready = en && state in {FILL, RUN}.
- Step:
  - FILL/RUN: en && in_valid && in_ready. DRAIN: en alone.
  - No step means no state change. in_valid low stalls row, mem_addr and window output.
- On an accepted step: bank[wbank][row] <= in_data; mem_addr += ADDR_STEP (wraps mod 2^ADDR_W).
- All banks are addressed with row. Bank read latency is 1 cycle.
- Row/pass counters:
  - row increments per step. At row==DEPTH-1 it wraps to 0; wbank advances mod NUM_BANKS; pass_cnt increments.
  - FILL -> RUN when pass_cnt reaches NUM_BANKS-1.
  - RUN -> DRAIN when pass_cnt reaches BLOCKS_PER_LINE.
  - DRAIN -> IDLE at the end of its pass. line_done pulses in the cycle after that final step.
- Window:
  - A step in RUN or DRAIN at row r with write bank w gives, one cycle later: win_valid=1 and win_data = top OUT_PIX pixels of {bank[w+1][r], bank[w+2][r], ..., bank[w+NUM_BANKS-1][r]} (indices mod NUM_BANKS).
  - In DRAIN, w is the bank that would have been written next.
  - The registered w/r copies used for muxing are captured at the step, so write-during-read never affects the selected banks.
  - win_valid=0 in every cycle not following such a step. win_data holds its last value when win_valid=0.
- next_block: pulses 1 in the cycle after a RUN/DRAIN step with r==NB_ADDR.
- line_start while not IDLE: abort and restart. Load line_base, enter FILL, clear row/wbank/pass_cnt, suppress any pending win_valid and line_done. line_start wins over a simultaneous step.
- en low: no step, no pulses; win_valid=0 during that cycle.
- Reset mid-line: immediate return to reset values. Bank contents are undefined and never read before a refill.
- Widths: row ceil(log2(DEPTH)), wbank ceil(log2(NUM_BANKS)), pass_cnt ceil(log2(BLOCKS_PER_LINE+1)).

Decomposition:
- Package ref_win_pkg: state enum (IDLE, FILL, RUN, DRAIN) and clog2-derived width constants.
- One sub-module, ref_bank_ram: single-port DEPTH x (PIX_W*PIX_PER_WORD) with registered read and write-enable. It is instantiated NUM_BANKS times in a generate loop and is swappable for a foundry macro.

Test Plan:
- Reset, then line_start with line_base=0x1000 and in_valid always 1, where word value = beat index -> first win_valid at cycle 3*23+1 after the first accept. First window = {w0[0], w23[0], w46[0][63:8]}; mem_addr=0x1000+8*70 at that point.
- Full line at defaults -> exactly 482*23 accepted beats, 479*23+23 win_valid cycles, 480 next_block pulses, line_done once, then in_ready=0 and IDLE.
- Random in_valid (50%) and en gaps -> window sequence and mem_addr identical to the no-stall run, just stretched; no win_valid while en=0.
- line_start asserted mid-RUN at pass 100 -> no stale win_valid after it, mem_addr=new line_base, FILL restarts; a simultaneous accept is ignored.
- Async rst pulse between clock edges mid-RUN -> outputs 0 immediately, without waiting for clk.
- Parameter sweep NUM_BANKS=3, DEPTH=16, OUT_PIX=12, PIX_PER_WORD=8 -> the scoreboard model matches window ordering and truncation.
